axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 slave backing a single-port 64-bit SRAM. Sits directly downstream of the core's AXI
//  master port (m_axi_* of the CROSP core) and serves instruction/data cache refills and writebacks.
//  Handles one transaction at a time, with FIXED/INCR/WRAP bursts, byte strobes and error responses.
// PARAMETERS
//  depth   16384         number of 64-bit words (power of two)
//  base    64'h80000000  byte address of word 0
//  idw     8             AXI ID width
// PORTS
//  clk                               in   1      clock, rising edge
//  rst                               in   1      asynchronous reset, active-low
//  s_axi_awid/awaddr/awlen           in   idw/64/8  write address, burst length-1
//  s_axi_awsize/awburst              in   3/2    beat size, burst type (0 FIXED, 1 INCR, 2 WRAP)
//  s_axi_awlock/awcache/awprot/awqos in   1/4/3/4  accepted and ignored
//  s_axi_awvalid / s_axi_awready     in/out 1    AW handshake
//  s_axi_wdata/wstrb/wlast           in   64/8/1 write data beat
//  s_axi_wvalid / s_axi_wready       in/out 1    W handshake
//  s_axi_bid/bresp                   out  idw/2  write response
//  s_axi_bvalid / s_axi_bready       out/in 1    B handshake
//  s_axi_arid/araddr/arlen/arsize/arburst  in  idw/64/8/3/2  read address
//  s_axi_arlock/arcache/arprot/arqos in   1/4/3/4  ignored
//  s_axi_arvalid / s_axi_arready     in/out 1    AR handshake
//  s_axi_rid/rdata/rresp/rlast       out  idw/64/2/1  read data beat
//  s_axi_rvalid / s_axi_rready       out/in 1    R handshake
// BEHAVIOUR
//  - Reset (rst=0, async): FSM to IDLE; all valid/ready outputs 0; rdata/rid/bid/resp 0; RAM contents unchanged.
//  - FSM: IDLE -> RD (AR accepted) | WR (AW accepted); WR -> WRESP (last beat accepted);
//    WRESP -> IDLE (bvalid&&bready); RD -> IDLE (rlast beat accepted, rvalid&&rready&&rlast).
//  - IDLE: awready = arready = 1 only for the channel the arbiter grants. If both are valid in
//    the same cycle, priority alternates: the type not served last wins. Reset value of the
//    toggle favours read.
//  - Beat address: FIXED holds the start address. INCR adds 1<<size per beat. WRAP adds
//    1<<size and wraps within an aligned window of (len+1)<<size bytes. Word index =
//    (addr-base)>>3. len is 8 bits, so a burst has up to 256 beats.
//  - Error checks, latched at AW/AR accept:
//    - address outside [base, base+8*depth) -> DECERR (2'b11);
//    - size>3, or WRAP with len not in {1,3,7,15} -> SLVERR (2'b10);
//    - otherwise OKAY.
//    An errored burst still completes all len+1 beats: no RAM writes, read data 0.
//  - WR: wready=1. Each accepted beat writes the byte lanes where wstrb[i]=1. Beat counter
//    ends the burst at len. If wlast disagrees with the counter, bresp=SLVERR (data already
//    written stays written). bid = latched awid.
//  - RD: RAM read latency is 1 cycle. The output register holds rdata/rlast while
//    rvalid && !rready. The next beat's RAM read issues when !rvalid || rready, which sustains
//    1 beat/cycle under continuous rready. rid = latched arid. rresp is the same on every beat.
//    rlast=1 only on beat len.
//  - No outstanding overlap: AW/AR are not accepted again until the FSM returns to IDLE.
//    This gives at least 1 idle cycle between transactions. The W channel is ignored outside WR.
//  - A reset during a burst abandons it. No response is issued afterwards; a partially written
//    burst leaves its earlier beats in RAM.
// TESTING
//  1. AW addr=0x80000000 len=3 size=3 INCR, 4 beats D0..D3 strb=FF, bready=1
//     -> bresp=0, bid=awid. Then AR same address, len=3 -> rdata D0..D3, rlast on beat 3,
//     one beat/cycle.
//  2. WRAP read, araddr=0x80000018 len=3 size=3 -> word order 3,0,1,2.
//     FIXED len=2 -> word 3 returned three times.
//  3. Write strb=0x0F data=0x1111111122222222 over 0xAAAAAAAAAAAAAAAA
//     -> read returns 0xAAAAAAAA22222222.
//  4. AR to 0x00001000 len=1 -> 2 beats, rdata 0, rresp=3. AW size=4 -> bresp=2, RAM unchanged.
//  5. AW and AR valid in the same cycle, twice in succession
//     -> first read served, then write, then read again (alternation).
//     rready toggled 1/0 during a read -> no beat lost or duplicated.
//  6. Deassert rst mid-read at beat 2 of 8
//     -> rvalid=0 next cycle, FSM IDLE, arready=1 after reset release; new burst is correct.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave in front of a single-port 64-bit SRAM.
// Serves one burst at a time (FIXED/INCR/WRAP) with byte strobes and OKAY/SLVERR/DECERR responses.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   s_axi_aw* / s_axi_w*     write address and write data channels
//   s_axi_b*                 write response channel
//   s_axi_ar* / s_axi_r*     read address and read data channels
//   *lock/*cache/*prot/*qos  accepted and ignored
module axi_sram_slave #(
  parameter int unsigned depth = 16384,
  parameter logic [63:0] base  = 64'h8000_0000,
  parameter int unsigned idw   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [idw-1:0] s_axi_awid,
  input  logic [63:0]    s_axi_awaddr,
  input  logic [7:0]     s_axi_awlen,
  input  logic [2:0]     s_axi_awsize,
  input  logic [1:0]     s_axi_awburst,
  input  logic           s_axi_awlock,
  input  logic [3:0]     s_axi_awcache,
  input  logic [2:0]     s_axi_awprot,
  input  logic [3:0]     s_axi_awqos,
  input  logic           s_axi_awvalid,
  output logic           s_axi_awready,
  input  logic [63:0]    s_axi_wdata,
  input  logic [7:0]     s_axi_wstrb,
  input  logic           s_axi_wlast,
  input  logic           s_axi_wvalid,
  output logic           s_axi_wready,
  output logic [idw-1:0] s_axi_bid,
  output logic [1:0]     s_axi_bresp,
  output logic           s_axi_bvalid,
  input  logic           s_axi_bready,
  input  logic [idw-1:0] s_axi_arid,
  input  logic [63:0]    s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arlock,
  input  logic [3:0]     s_axi_arcache,
  input  logic [2:0]     s_axi_arprot,
  input  logic [3:0]     s_axi_arqos,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [idw-1:0] s_axi_rid,
  output logic [63:0]    s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready
);

  localparam int unsigned aw        = $clog2(depth);
  localparam logic [63:0] mem_bytes = 64'(depth) << 3;
  localparam logic [1:0]  resp_okay   = 2'b00;
  localparam logic [1:0]  resp_slverr = 2'b10;
  localparam logic [1:0]  resp_decerr = 2'b11;

  typedef enum logic [1:0] {st_idle, st_rd, st_wr, st_wresp} state_t;

  state_t      state;
  logic        prefer_rd;
  logic [63:0] cur_addr;
  logic [7:0]  cur_len;
  logic [2:0]  cur_size;
  logic [1:0]  cur_burst;
  logic [1:0]  cur_resp;
  logic [8:0]  beat;
  logic        wlast_err;

  logic [63:0] mem [depth];

  // Response class of a request, decided once when the address is accepted.
  function automatic logic [1:0] check_req(input logic [63:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] off;
    off = addr - base;
    if (addr < base || off >= mem_bytes) return resp_decerr;
    if (size > 3'd3) return resp_slverr;
    if (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return resp_slverr;
    return resp_okay;
  endfunction

  // Address of the following beat; WRAP stays inside its (len+1)<<size aligned window.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] inc;
    logic [63:0] mask;
    inc  = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      2'd0:    return addr;
      2'd2:    return (addr & ~mask) | ((addr + inc) & mask);
      default: return addr + inc;
    endcase
  endfunction

  logic [63:0]   cur_off;
  logic [aw-1:0] cur_idx;
  logic [1:0]    ar_resp;
  logic [1:0]    aw_resp;
  logic          ar_hs;
  logic          aw_hs;
  logic          w_hs;
  logic          ram_we;
  logic          rd_all_issued;
  logic          rd_issue;
  logic          grant_rd;
  logic          grant_wr;

  assign cur_off       = cur_addr - base;
  assign cur_idx       = cur_off[aw+2:3];
  assign ar_resp       = check_req(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
  assign aw_resp       = check_req(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = (state == st_wr) && s_axi_wvalid && s_axi_wready;
  assign ram_we        = w_hs && (cur_resp == resp_okay);
  assign rd_all_issued = beat > {1'b0, cur_len};
  // Next read issues when the output register is empty or being drained this cycle.
  assign rd_issue      = (state == st_rd) && !rd_all_issued && (!s_axi_rvalid || s_axi_rready);
  // Alternating priority when both address channels request together.
  assign grant_rd      = s_axi_arvalid && (!s_axi_awvalid || prefer_rd);
  assign grant_wr      = s_axi_awvalid && (!s_axi_arvalid || !prefer_rd);

  // SRAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i]) mem[cur_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered channel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= st_idle;
      prefer_rd     <= 1'b1;
      cur_addr      <= '0;
      cur_len       <= '0;
      cur_size      <= '0;
      cur_burst     <= '0;
      cur_resp      <= resp_okay;
      beat          <= '0;
      wlast_err     <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      s_axi_rlast   <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (ar_hs) begin
            state         <= st_rd;
            s_axi_arready <= 1'b0;
            s_axi_awready <= 1'b0;
            prefer_rd     <= 1'b0;
            cur_addr      <= s_axi_araddr;
            cur_len       <= s_axi_arlen;
            cur_size      <= s_axi_arsize;
            cur_burst     <= s_axi_arburst;
            cur_resp      <= ar_resp;
            beat          <= '0;
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= ar_resp;
          end else if (aw_hs) begin
            state         <= st_wr;
            s_axi_arready <= 1'b0;
            s_axi_awready <= 1'b0;
            prefer_rd     <= 1'b1;
            cur_addr      <= s_axi_awaddr;
            cur_len       <= s_axi_awlen;
            cur_size      <= s_axi_awsize;
            cur_burst     <= s_axi_awburst;
            cur_resp      <= aw_resp;
            beat          <= '0;
            wlast_err     <= 1'b0;
            s_axi_bid     <= s_axi_awid;
            s_axi_wready  <= 1'b1;
          end else begin
            s_axi_arready <= grant_rd;
            s_axi_awready <= grant_wr;
          end
        end
        st_wr: begin
          if (w_hs) begin
            beat     <= beat + 9'd1;
            cur_addr <= next_addr(cur_addr, cur_len, cur_size, cur_burst);
            if (beat == {1'b0, cur_len}) begin
              state        <= st_wresp;
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              if (cur_resp != resp_okay)        s_axi_bresp <= cur_resp;
              else if (wlast_err || !s_axi_wlast) s_axi_bresp <= resp_slverr;
              else                               s_axi_bresp <= resp_okay;
            end else if (s_axi_wlast) begin
              wlast_err <= 1'b1;
            end
          end
        end
        st_wresp: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= st_idle;
          end
        end
        st_rd: begin
          if (rd_issue) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= (cur_resp == resp_okay) ? mem[cur_idx] : 64'd0;
            s_axi_rlast  <= (beat == {1'b0, cur_len});
            beat         <= beat + 9'd1;
            cur_addr     <= next_addr(cur_addr, cur_len, cur_size, cur_burst);
          end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (s_axi_rlast) state <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                       cur_off[63:aw+3], cur_off[2:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected R/B responses from a
// burst-level memory model; monitors pop and compare on every R/B handshake.
module tb_axi_sram_slave;

  localparam int unsigned DEPTH = 16384;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int unsigned IDW   = 8;

  logic clk = 1'b0;
  logic rst;
  logic [IDW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [63:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awlock, s_axi_arlock;
  logic [3:0]  s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_sram_slave #(.depth(DEPTH), .base(BASE), .idw(IDW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [7:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [7:0] id; } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  logic  order_q[$];          // 1 = AR accepted, 0 = AW accepted
  int    rcyc[$];
  logic [63:0] mm [int unsigned];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  int checks = 0, passed = 0, cyc = 0, r_seen = 0;
  logic rmode = 1'b0, bmode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    checks++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] exp_resp(input logic [63:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    if (a < BASE || a >= BASE + 64'(DEPTH) * 64'd8) return 2'b11;
    if (size > 3'd3) return 2'b10;
    if (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int k);
    logic [63:0] nb, win, lo;
    nb = 64'd1 << size;
    if (burst == 2'd0) return a;
    if (burst == 2'd2) begin
      win = (64'(len) + 64'd1) * nb;
      lo  = (a / win) * win;
      return lo + ((a - lo + 64'(k) * nb) % win);
    end
    return a + 64'(k) * nb;
  endfunction

  function automatic int unsigned widx(input logic [63:0] a);
    logic [63:0] w;
    w = ((a - BASE) >> 3) % 64'(DEPTH);
    return 32'(w);
  endfunction

  function automatic logic [63:0] mm_rd(input int unsigned i);
    return mm.exists(i) ? mm[i] : 64'h0;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_read(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [7:0] id);
    logic [1:0] resp;
    rexp_t e;
    int n;
    resp = exp_resp(a, len, size, burst);
    for (int k = 0; k <= int'(len); k++) begin
      e.data = (resp == 2'b00) ? mm_rd(widx(beat_addr(a, len, size, burst, k))) : 64'h0;
      e.resp = resp;
      e.last = (k == int'(len));
      e.id   = id;
      rq.push_back(e);
    end
    @(posedge clk); #1;
    s_axi_araddr = a; s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arid = id; s_axi_arvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axi_arready) break;
      n++;
      if (n >= 2000) begin tmo("ar_handshake"); break; end
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  // badk >= 0 flips wlast on that beat
  task automatic do_write(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] id, input int badk);
    logic [1:0] resp;
    logic [63:0] w;
    int unsigned i;
    bexp_t be;
    int n;
    resp = exp_resp(a, len, size, burst);
    if (resp == 2'b00) begin
      for (int k = 0; k <= int'(len); k++) begin
        i = widx(beat_addr(a, len, size, burst, k));
        w = mm_rd(i);
        for (int b = 0; b < 8; b++) if (ws[k][b]) w[8*b +: 8] = wd[k][8*b +: 8];
        mm[i] = w;
      end
    end
    be.resp = (resp == 2'b00 && badk >= 0) ? 2'b10 : resp;
    be.id   = id;
    bq.push_back(be);
    @(posedge clk); #1;
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awid = id; s_axi_awvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axi_awready) break;
      n++;
      if (n >= 2000) begin tmo("aw_handshake"); break; end
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      s_axi_wdata = wd[k]; s_axi_wstrb = ws[k];
      s_axi_wlast = (k == int'(len)) ^ (k == badk);
      s_axi_wvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (s_axi_wready) break;
        n++;
        if (n >= 2000) begin tmo("w_handshake"); break; end
      end
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) tmo("drain");
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && s_axi_rvalid && s_axi_rready) begin
      rexp_t e;
      r_seen = r_seen + 1;
      rcyc.push_back(cyc);
      if (rq.size() == 0) begin
        checks++;
        $display("FAIL r_unexpected actual=beat rdata=%h required=no beat", s_axi_rdata);
      end else begin
        e = rq.pop_front();
        chk("rdata", s_axi_rdata, e.data);
        chk("r_resp_last_id", 64'({s_axi_rresp, s_axi_rlast, s_axi_rid}), 64'({e.resp, e.last, e.id}));
      end
    end
    if (rst && s_axi_bvalid && s_axi_bready) begin
      bexp_t e;
      if (bq.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected actual=response required=none");
      end else begin
        e = bq.pop_front();
        chk("b_resp_id", 64'({s_axi_bresp, s_axi_bid}), 64'({e.resp, e.id}));
      end
    end
    if (rst && s_axi_arvalid && s_axi_arready) order_q.push_back(1'b1);
    if (rst && s_axi_awvalid && s_axi_awready) order_q.push_back(1'b0);
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      s_axi_rready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axi_bready = bmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r0, n;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [63:0] a;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                          s_axi_rvalid, s_axi_rlast}), 64'd0);
    chk("reset_rdata", s_axi_rdata, 64'd0);
    chk("reset_ids", 64'({s_axi_rid, s_axi_bid, s_axi_rresp, s_axi_bresp}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // preload words 0..63 with one long INCR burst
    for (int k = 0; k < 64; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
    do_write(BASE, 8'd63, 3'd3, 2'd1, 8'h01, -1);

    // INCR write then read back at full rate
    wd[0] = 64'hD0D0_0000_0000_00D0; wd[1] = 64'hD1D1_1111_1111_11D1;
    wd[2] = 64'hD2D2_2222_2222_22D2; wd[3] = 64'hD3D3_3333_3333_33D3;
    for (int k = 0; k < 4; k++) ws[k] = 8'hFF;
    do_write(BASE, 8'd3, 3'd3, 2'd1, 8'h5A, -1);
    wait_done();
    rcyc.delete();
    do_read(BASE, 8'd3, 3'd3, 2'd1, 8'hA5);
    wait_done();
    chk("r_beat_count", 64'(rcyc.size()), 64'd4);
    if (rcyc.size() == 4) chk("r_one_per_cycle", 64'(rcyc[3] - rcyc[0]), 64'd3);

    // WRAP order 3,0,1,2 and FIXED repeat
    do_read(BASE + 64'h18, 8'd3, 3'd3, 2'd2, 8'h11);
    do_read(BASE + 64'h18, 8'd2, 3'd3, 2'd0, 8'h12);

    // partial strobe merge
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; ws[0] = 8'hFF;
    do_write(BASE + 64'h40, 8'd0, 3'd3, 2'd1, 8'h03, -1);
    wd[0] = 64'h1111_1111_2222_2222; ws[0] = 8'h0F;
    do_write(BASE + 64'h40, 8'd0, 3'd3, 2'd1, 8'h04, -1);
    do_read(BASE + 64'h40, 8'd0, 3'd3, 2'd1, 8'h05);

    // error responses; RAM must remain intact, wlast mismatch flags SLVERR
    do_read(64'h1000, 8'd1, 3'd3, 2'd1, 8'h06);
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
    do_write(BASE, 8'd0, 3'd4, 2'd1, 8'h07, -1);
    do_read(BASE, 8'd0, 3'd3, 2'd1, 8'h08);
    wd[0] = 64'h0123_4567_89AB_CDEF; wd[1] = 64'hFEDC_BA98_7654_3210; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(BASE + 64'h50, 8'd1, 3'd3, 2'd1, 8'h09, 1);
    wait_done();

    // simultaneous AW/AR twice: expect R, W, R, W with throttled rready
    order_q.delete();
    rmode = 1'b1;
    for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
    fork
      do_write(BASE + 64'd320, 8'd3, 3'd3, 2'd1, 8'h21, -1);
      do_read(BASE, 8'd7, 3'd3, 2'd1, 8'h22);
    join
    for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'h5A; end
    fork
      do_write(BASE + 64'd352, 8'd3, 3'd3, 2'd1, 8'h23, -1);
      do_read(BASE + 64'd8, 8'd7, 3'd3, 2'd1, 8'h24);
    join
    wait_done();
    chk("arb_count", 64'(order_q.size()), 64'd4);
    if (order_q.size() == 4)
      chk("arb_order", 64'({order_q[0], order_q[1], order_q[2], order_q[3]}), 64'b1010);

    // reset in the middle of an 8-beat read
    rmode = 1'b0;
    r0 = r_seen;
    do_read(BASE, 8'd7, 3'd3, 2'd1, 8'h31);
    n = 0;
    while (r_seen < r0 + 2 && n < 200) begin @(negedge clk); n++; end
    if (r_seen < r0 + 2) tmo("reset_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    rq.delete();
    @(negedge clk);
    chk("reset_mid_rvalid", 64'({s_axi_rvalid, s_axi_arready, s_axi_awready}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_read(BASE, 8'd7, 3'd3, 2'd1, 8'h32);
    wait_done();

    // randomized mix including error cases
    rmode = 1'b1;
    bmode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int sel;
      sel   = $urandom_range(0, 9);
      burst = 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 3));
      len   = (burst == 2'd2) ? 8'(1 << $urandom_range(1, 4)) - 8'd1 : 8'($urandom_range(0, 15));
      a = BASE + 64'($urandom_range(0, 31)) * 64'd8 +
          (64'($urandom_range(0, 7)) & ~((64'd1 << size) - 64'd1));
      if (sel == 0) a = 64'h1000;
      if (sel == 1) size = 3'($urandom_range(4, 7));
      if (sel == 2) begin burst = 2'd2; len = 8'd2; end
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= int'(len); k++) begin
          wd[k] = {$urandom, $urandom};
          ws[k] = 8'($urandom_range(0, 255));
        end
        do_write(a, len, size, burst, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1);
      end else begin
        do_read(a, len, size, burst, 8'($urandom_range(0, 255)));
      end
    end
    wait_done();
    chk("leftover_expected", 64'(rq.size() + bq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
